seg7_readback: RTL
==================

SEG7_READBACK -- requirements
Module: seg7_readback

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive unchanged samples required before a digit is latched (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port enable, input, 1, capture enable.
REQ-005 SHALL have port seg7_sel, input, 3, display position currently driven (0..7).
REQ-006 SHALL have port seg7_in, input, 7, segment pattern, bit6..bit0 = a..g, active-high.
REQ-007 SHALL have port dpt_in, input, 1, decimal point for the driven position.
REQ-008 SHALL have port err_clr, input, 1, clears seg_err.
REQ-009 SHALL have port rd_sel, input, 3, read-back position.
REQ-010 SHALL have port rd_bcd, output, 4, stored BCD at rd_sel.
REQ-011 SHALL have port rd_valid, output, 1, stored entry at rd_sel holds a decoded digit.
REQ-012 SHALL have port rd_dpt, output, 1, stored decimal point at rd_sel.
REQ-013 SHALL have port digit_strobe, output, 1, one-cycle pulse per latch event.
REQ-014 SHALL have port strobe_pos, output, 3, position of the latest latch.
REQ-015 SHALL have port strobe_bcd, output, 4, decoded value of the latest latch.
REQ-016 SHALL have port seg_err, output, 1, sticky illegal-pattern flag.

Function
REQ-017 SHALL register {seg7_sel, seg7_in, dpt_in} every cycle into sample s; any bit difference from the previous s counts as a change, including a seg7_sel-only change.
REQ-018 SHALL use FSM states IDLE, TRACK, HOLD: IDLE->TRACK when enable=1; any state->IDLE when enable=0; TRACK->HOLD on latch; HOLD->TRACK when s changes.
REQ-019 SHALL clear the stability counter on a change of s and in IDLE, otherwise increment it in TRACK, saturating at STABLE_CYCLES.
REQ-020 SHALL latch when in TRACK, s is unchanged, and the counter equals STABLE_CYCLES-1; digit_strobe then goes high for exactly one cycle, after rising edge STABLE_CYCLES+1 counted from the first edge that samples the new input.
REQ-021 SHALL latch at most once per stable window; no further strobe occurs in HOLD.
REQ-022 SHALL decode a..g as 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
REQ-023 SHALL on a legal latch write entry[sel] = {bcd, valid=1, dpt}, set strobe_bcd=bcd.
REQ-024 SHALL on a blank latch (0000000) write entry[sel] = {0, valid=0, dpt}, set strobe_bcd=4'hF, and not set seg_err.
REQ-025 SHALL on any other pattern write entry[sel] = {4'hF, valid=0, dpt}, set strobe_bcd=4'hF, and set seg_err.
REQ-026 SHALL update strobe_pos and strobe_bcd only on latch and hold them otherwise.
REQ-027 SHALL register rd_bcd, rd_valid and rd_dpt from entry[rd_sel] with one-cycle latency; on a same-cycle write and read of one position, the old value is returned first and the new value on the following cycle.
REQ-028 SHALL clear seg_err on err_clr=1, except that a simultaneous illegal latch keeps seg_err set (set wins).
REQ-029 SHALL retain all stored entries while enable=0.

Reset
REQ-030 SHALL, with reset=0 at any time (including mid-window), force IDLE, counter 0, s 0, all 8 entries {0,0,0}, and rd_bcd, rd_valid, rd_dpt, digit_strobe, strobe_pos, strobe_bcd, seg_err all 0.
REQ-031 SHALL resume operation on the first rising clk edge after reset returns to 1; no latch occurs before a full stable window.

Verification
REQ-032 SHALL verify: STABLE_CYCLES=4, enable=1, sel=5, seg7_in=1011011, dpt_in=1 held -> single strobe after edge 5, strobe_pos=5, strobe_bcd=5; rd_sel=5 -> rd_bcd=5, rd_valid=1, rd_dpt=1.
REQ-033 SHALL verify: pattern held 3 cycles, then changed to 0110000 and held -> no strobe for the first pattern, one strobe with strobe_bcd=1.
REQ-034 SHALL verify: pattern 1000001 latched at sel=2 -> seg_err=1, entry 2 = {F,0}; err_clr pulse -> seg_err=0; err_clr coinciding with a second illegal latch -> seg_err stays 1.
REQ-035 SHALL verify: sweep of sel 0..7 holding digits 0..9 with blank on sel 7 -> 8 strobes, rd_sel readback matches, rd_valid=0 at position 7, seg_err=0.
REQ-036 SHALL verify: reset=0 asserted two cycles into a stable window after prior latches -> all outputs and entries 0 immediately; no strobe until 5 edges after reset release.
REQ-037 SHALL verify: enable=0 with changing inputs -> no strobe and entries unchanged; enable=1 -> normal latch after a stable window.

Source files
------------

// File: rtl/seg7_readback.sv
// seg7_readback
//   Watches a multiplexed 7-segment display bus. A position is latched only
//   after the {position, segments, decimal point} sample has held still for
//   STABLE_CYCLES consecutive clocks. The latched pattern is decoded to BCD
//   and stored per position for read-back.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low
//   enable       : capture enable (0 = idle, stored entries retained)
//   seg7_sel     : display position currently driven (0..7)
//   seg7_in      : segments a..g on bit6..bit0, active-high
//   dpt_in       : decimal point for the driven position
//   err_clr      : clears seg_err (a simultaneous illegal latch wins)
//   rd_sel       : read-back position
//   rd_bcd       : stored BCD at rd_sel, one-cycle latency
//   rd_valid     : stored entry at rd_sel holds a decoded digit
//   rd_dpt       : stored decimal point at rd_sel
//   digit_strobe : one-cycle pulse per latch event
//   strobe_pos   : position of the latest latch
//   strobe_bcd   : decoded value of the latest latch (F = blank/illegal)
//   seg_err      : sticky illegal-pattern flag
module seg7_readback #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] seg7_sel,
  input  logic [6:0] seg7_in,
  input  logic       dpt_in,
  input  logic       err_clr,
  input  logic [2:0] rd_sel,
  output logic [3:0] rd_bcd,
  output logic       rd_valid,
  output logic       rd_dpt,
  output logic       digit_strobe,
  output logic [2:0] strobe_pos,
  output logic [3:0] strobe_bcd,
  output logic       seg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LATCH = 8'(STABLE_CYCLES - 1);

  // Decode result packed as {bcd[3:0], legal, blank}. Blank carries bcd 0
  // and illegal carries bcd F so both can be stored without further muxing.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] d;
    d = {4'hF, 2'b00};
    case (seg)
      7'b1111110: d = {4'd0, 2'b10};
      7'b0110000: d = {4'd1, 2'b10};
      7'b1101101: d = {4'd2, 2'b10};
      7'b1111001: d = {4'd3, 2'b10};
      7'b0110011: d = {4'd4, 2'b10};
      7'b1011011: d = {4'd5, 2'b10};
      7'b1011111: d = {4'd6, 2'b10};
      7'b1110000: d = {4'd7, 2'b10};
      7'b1111111: d = {4'd8, 2'b10};
      7'b1111011: d = {4'd9, 2'b10};
      7'b0000000: d = {4'd0, 2'b01};
      default:    d = {4'hF, 2'b00};
    endcase
    return d;
  endfunction

  logic [10:0] w_smp;
  logic [10:0] r_s_p0;
  logic        w_change;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        w_latch;
  logic [5:0]  w_dec;
  logic        w_illegal;
  logic [5:0]  r_entry [8];

  // A change is the incoming sample differing from the held one, so the
  // counter restarts on the same edge that first samples new input.
  assign w_smp     = {seg7_sel, seg7_in, dpt_in};
  assign w_change  = (w_smp != r_s_p0);
  assign w_latch   = enable && (r_state == TRACK) && !w_change && (r_cnt == CNT_LATCH);
  assign w_dec     = decode_seg(r_s_p0[7:1]);
  assign w_illegal = !w_dec[1] && !w_dec[0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = TRACK;
      TRACK:   if (w_latch) w_state_nxt = HOLD;
      HOLD:    if (w_change) w_state_nxt = TRACK;
      default: w_state_nxt = IDLE;
    endcase
    if (!enable) w_state_nxt = IDLE;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_change || (r_state == IDLE)) begin
      w_cnt_nxt = 8'd0;
    end else if ((r_state == TRACK) && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  // Stage p0: sample register, FSM and stability counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_p0  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_s_p0  <= w_smp;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stage p1: entry store, strobe outputs, error flag and read-back port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_entry[i] <= '0;
      rd_bcd       <= '0;
      rd_valid     <= 1'b0;
      rd_dpt       <= 1'b0;
      digit_strobe <= 1'b0;
      strobe_pos   <= '0;
      strobe_bcd   <= '0;
      seg_err      <= 1'b0;
    end else begin
      // Read sees the pre-write contents when the same position is written.
      rd_bcd       <= r_entry[rd_sel][5:2];
      rd_valid     <= r_entry[rd_sel][1];
      rd_dpt       <= r_entry[rd_sel][0];
      digit_strobe <= w_latch;
      if (w_latch) begin
        r_entry[r_s_p0[10:8]] <= {w_dec[5:2], w_dec[1], r_s_p0[0]};
        strobe_pos            <= r_s_p0[10:8];
        strobe_bcd            <= w_dec[1] ? w_dec[5:2] : 4'hF;
      end
      if (w_latch && w_illegal) begin
        seg_err <= 1'b1;
      end else if (err_clr) begin
        seg_err <= 1'b0;
      end
    end
  end

endmodule
